console_stream_mux: RTL and testbench

//  Multi-channel console capture for picorv32 system builds: collects out_byte/out_byte_en character streams
//  and trap flags from NUM_CH cores, buffers each channel in a FIFO and drains them round-robin onto one

---
 rtl/console_pkg.sv | 12 +
 rtl/console_fifo.sv | 62 ++++++
 rtl/console_stream_mux.sv | 166 ++++++++++++++++
 tb/tb_console_stream_mux.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants and helpers for the multi-channel console capture block.
package console_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    // Channel index width; a single channel still needs a 1-bit tag.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Per-channel synchronous FIFO with combinational head read so a fresh byte
// can reach the output register on the cycle after it is written.
module console_fifo
    import console_pkg::*;
#(
    parameter int  DATA_W = DEFAULT_DATA_W,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_ok   = pop & ~empty;
    // A full FIFO still takes a write when its head leaves in the same cycle.
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/console_stream_mux.sv
// Collects per-core console byte streams into FIFOs and drains them round-robin
// onto one tagged valid/ready stream, with overflow, trap, done and watchdog status.
module console_stream_mux
    import console_pkg::*;
#(
    parameter int  NUM_CH  = 2,
    parameter int  DATA_W  = DEFAULT_DATA_W,
    parameter int  DEPTH   = DEFAULT_DEPTH,
    parameter int  TIMEOUT = 0,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CH*DATA_W-1:0] ch_byte,
    input  logic [NUM_CH-1:0]        ch_byte_en,
    input  logic [NUM_CH-1:0]        ch_trap,
    input  logic                     clr_sticky,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [CH_W-1:0]          m_chan,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH-1:0]        trapped,
    output logic                     done,
    output logic                     timeout
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [DATA_W-1:0] fifo_data  [NUM_CH];
    logic [CNT_W-1:0]  fifo_count [NUM_CH];
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_push;
    logic [NUM_CH-1:0] fifo_pop;

    logic              m_valid_reg;
    logic [DATA_W-1:0] m_data_reg;
    logic [CH_W-1:0]   m_chan_reg;
    logic [CH_W-1:0]   grant_reg;
    logic [NUM_CH-1:0] overflow_reg, overflow_next;
    logic [NUM_CH-1:0] trapped_reg, trapped_next;
    logic              done_reg, done_next;
    logic              timeout_reg, timeout_next;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;

    logic              load_ok;
    logic              sel_found;
    logic [CH_W-1:0]   sel;
    logic              all_empty;
    logic              activity;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign fifo_push[gi] = ch_byte_en[gi] & ~trapped_reg[gi];

            console_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .resetn    (resetn),
                .push      (fifo_push[gi]),
                .push_data (ch_byte[gi*DATA_W +: DATA_W]),
                .pop       (fifo_pop[gi]),
                .pop_data  (fifo_data[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi]),
                .count     (fifo_count[gi])
            );
        end
    endgenerate

    assign load_ok = ~m_valid_reg | m_ready;

    // Search starts one past the last served channel so every channel gets a turn.
    always_comb begin
        int idx;
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(grant_reg) + k) % NUM_CH;
            if (!sel_found && !fifo_empty[idx]) begin
                sel_found = 1'b1;
                sel       = CH_W'(idx);
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (load_ok && sel_found) begin
            fifo_pop[sel] = 1'b1;
        end
    end

    always_comb begin
        all_empty = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (fifo_count[k] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    always_comb begin
        activity      = (|ch_byte_en) | (m_valid_reg & m_ready);
        overflow_next = (fifo_push & fifo_full & ~fifo_pop)
                      | (overflow_reg & ~{NUM_CH{clr_sticky}});
        trapped_next  = trapped_reg | ch_trap;
        done_next     = done_reg | ((&trapped_reg) & all_empty & ~m_valid_reg);

        wd_cnt_next = wd_cnt_reg;
        if (TIMEOUT == 0 || done_reg || activity || clr_sticky) begin
            wd_cnt_next = '0;
        end else if (wd_cnt_reg != WD_W'(TIMEOUT)) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
        end
        timeout_next = ((TIMEOUT > 0) && (wd_cnt_next == WD_W'(TIMEOUT)))
                     | (timeout_reg & ~clr_sticky);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_chan_reg  <= '0;
            grant_reg   <= CH_W'(NUM_CH - 1);
        end else if (load_ok) begin
            m_valid_reg <= sel_found;
            if (sel_found) begin
                m_data_reg <= fifo_data[sel];
                m_chan_reg <= sel;
                grant_reg  <= sel;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_reg <= '0;
            trapped_reg  <= '0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            wd_cnt_reg   <= '0;
        end else begin
            overflow_reg <= overflow_next;
            trapped_reg  <= trapped_next;
            done_reg     <= done_next;
            timeout_reg  <= timeout_next;
            wd_cnt_reg   <= wd_cnt_next;
        end
    end

    assign m_valid  = m_valid_reg;
    assign m_data   = m_data_reg;
    assign m_chan   = m_chan_reg;
    assign overflow = overflow_reg;
    assign trapped  = trapped_reg;
    assign done     = done_reg;
    assign timeout  = timeout_reg;

endmodule

// File: tb/tb_console_stream_mux.sv
// Scenario bench for console_stream_mux: two channels, depth 16, watchdog of 50 cycles.
module tb_console_stream_mux;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 50;

    logic                     clk;
    logic                     resetn;
    logic [NUM_CH*DATA_W-1:0] ch_byte;
    logic [NUM_CH-1:0]        ch_byte_en;
    logic [NUM_CH-1:0]        ch_trap;
    logic                     clr_sticky;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic [0:0]               m_chan;
    logic [NUM_CH-1:0]        overflow;
    logic [NUM_CH-1:0]        trapped;
    logic                     done;
    logic                     timeout;

    typedef struct packed {
        logic [0:0] chan;
        logic [7:0] data;
    } beat_t;

    beat_t got_q [$];
    int    checks = 0;
    int    errors = 0;

    console_stream_mux #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ch_byte    (ch_byte),
        .ch_byte_en (ch_byte_en),
        .ch_trap    (ch_trap),
        .clr_sticky (clr_sticky),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_chan     (m_chan),
        .overflow   (overflow),
        .trapped    (trapped),
        .done       (done),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor: inputs change just after posedge, so the negedge sees the upcoming handshake.
    always @(negedge clk) begin
        if (resetn && m_valid && m_ready) begin
            got_q.push_back({m_chan, m_data});
            $display("beat: chan=%0d data=%02h", m_chan, m_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ch_byte    = '0;
        ch_byte_en = '0;
        ch_trap    = '0;
        clr_sticky = 1'b0;
        m_ready    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        got_q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        checks++;
        if ({m_valid, m_data, m_chan} !== 10'h0) begin
            errors++;
            $display("FAIL reset_stream: got %h expected 0", {m_valid, m_data, m_chan});
        end
        checks++;
        if ({overflow, trapped, done, timeout} !== 6'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected 0", {overflow, trapped, done, timeout});
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        logic [7:0] hi [3];
        hi[0] = 8'h48;
        hi[1] = 8'h69;
        hi[2] = 8'h0A;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_byte    = {8'h00, hi[i]};
            ch_byte_en = 2'b01;
            tick();
            if (i == 0) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_t1: got m_valid=%b expected 0", m_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if ({m_valid, m_chan, m_data} !== {1'b1, 1'b0, 8'h48}) begin
                    errors++;
                    $display("FAIL latency_t2: got %b/%0d/%02h expected 1/0/48", m_valid, m_chan, m_data);
                end
            end
        end
        ch_byte_en = '0;
        repeat (6) tick();
        checks++;
        if (got_q.size() !== 3) begin
            errors++;
            $display("FAIL single_count: got %0d expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== {1'b0, hi[i]}) begin
                    errors++;
                    $display("FAIL single_beat%0d: got %h expected %h", i, got_q[i], {1'b0, hi[i]});
                end
            end
        end
        $display("test_single: %0d beats", got_q.size());
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_q [2][$];
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch_byte    = 16'($urandom);
            ch_byte_en = 2'b11;
            exp_q[0].push_back(ch_byte[7:0]);
            exp_q[1].push_back(ch_byte[15:8]);
            tick();
        end
        ch_byte_en = '0;
        repeat (12) tick();
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 8", got_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                beat_t expb;
                expb.chan = 1'(k % 2);
                expb.data = exp_q[k % 2].pop_front();
                checks++;
                if (got_q[k] !== expb) begin
                    errors++;
                    $display("FAIL rr_beat%0d: got %h expected %h", k, got_q[k], expb);
                end
            end
        end
        $display("test_round_robin: %0d beats", got_q.size());
    endtask

    task automatic test_overflow();
        logic [7:0] sent [20];
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sent[i]    = 8'($urandom);
            ch_byte    = {8'h00, sent[i]};
            ch_byte_en = 2'b01;
            tick();
        end
        ch_byte_en = '0;
        tick();
        checks++;
        if (overflow !== 2'b01) begin
            errors++;
            $display("FAIL ovf_flag: got %b expected 01", overflow);
        end
        repeat (3) tick();
        checks++;
        if ({m_valid, m_data} !== {1'b1, sent[0]}) begin
            errors++;
            $display("FAIL ovf_hold: got %b/%02h expected 1/%02h", m_valid, m_data, sent[0]);
        end
        m_ready = 1'b1;
        repeat (25) tick();
        checks++;
        if (got_q.size() !== 17) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 17", got_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (got_q[i] !== {1'b0, sent[i]}) begin
                    errors++;
                    $display("FAIL ovf_beat%0d: got %h expected %h", i, got_q[i], {1'b0, sent[i]});
                end
            end
        end
        checks++;
        if (overflow !== 2'b01) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 01", overflow);
        end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++;
        if (overflow !== 2'b00) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 00", overflow);
        end
        $display("test_overflow: %0d beats", got_q.size());
    endtask

    task automatic test_trap_done();
        // Per cycle: {ch1_trap, ch1_en, ch0_trap, ch0_en}
        logic [3:0] sched [6];
        logic [7:0] exp_q [2][$];
        logic [1:0] model_trapped;
        int         budget;
        sched[0] = 4'b0101;
        sched[1] = 4'b0101;
        sched[2] = 4'b0110;
        sched[3] = 4'b0101;
        sched[4] = 4'b1100;
        sched[5] = 4'b0101;
        model_trapped = 2'b00;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            ch_byte    = 16'($urandom);
            ch_byte_en = {sched[c][2], sched[c][0]};
            ch_trap    = {sched[c][3], sched[c][1]};
            m_ready    = 1'($urandom_range(0, 1));
            for (int ch = 0; ch < 2; ch++) begin
                if (ch_byte_en[ch] && !model_trapped[ch]) begin
                    exp_q[ch].push_back(ch_byte[ch*8 +: 8]);
                end
            end
            model_trapped = model_trapped | ch_trap;
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_early_c%0d: got %b expected 0", c, done);
            end
        end
        ch_byte_en = '0;
        ch_trap    = '0;
        budget     = 0;
        while (got_q.size() < 7 && budget < 200) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            budget++;
            if (got_q.size() < 7) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_drain: got %b expected 0 with %0d delivered", done, got_q.size());
                end
            end
        end
        checks++;
        if (got_q.size() !== 7) begin
            errors++;
            $display("FAIL trap_count: got %0d expected 7", got_q.size());
        end
        checks++;
        if ({done, m_valid, trapped} !== 4'b0011) begin
            errors++;
            $display("FAIL trap_last: got done/valid/trapped %b expected 0011", {done, m_valid, trapped});
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_set: got %b expected 1", done);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            logic [7:0] expd;
            expd = (exp_q[got_q[k].chan].size() > 0) ? exp_q[got_q[k].chan].pop_front() : 8'hxx;
            checks++;
            if (got_q[k].data !== expd) begin
                errors++;
                $display("FAIL trap_beat%0d: got %02h expected %02h", k, got_q[k].data, expd);
            end
        end
        $display("test_trap_done: %0d beats, done=%b", got_q.size(), done);
    endtask

    task automatic test_random();
        logic [7:0] exp_q [2][$];
        int         total;
        int         budget;
        do_reset();
        total = 0;
        for (int c = 0; c < 400; c++) begin
            ch_byte    = 16'($urandom);
            ch_byte_en = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            m_ready    = ($urandom_range(0, 9) < 7);
            for (int ch = 0; ch < 2; ch++) begin
                if (ch_byte_en[ch]) begin
                    exp_q[ch].push_back(ch_byte[ch*8 +: 8]);
                    total++;
                end
            end
            tick();
        end
        ch_byte_en = '0;
        m_ready    = 1'b1;
        budget     = 0;
        while (got_q.size() < total && budget < 100) begin
            tick();
            budget++;
        end
        tick();
        checks++;
        if (got_q.size() !== total) begin
            errors++;
            $display("FAIL rand_count: got %0d expected %0d", got_q.size(), total);
        end
        checks++;
        if (overflow !== 2'b00) begin
            errors++;
            $display("FAIL rand_overflow: got %b expected 00", overflow);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            logic [7:0] expd;
            expd = (exp_q[got_q[k].chan].size() > 0) ? exp_q[got_q[k].chan].pop_front() : 8'hxx;
            checks++;
            if (got_q[k].data !== expd) begin
                errors++;
                $display("FAIL rand_beat%0d: got %02h expected %02h on chan %0d", k, got_q[k].data, expd, got_q[k].chan);
            end
        end
        $display("test_random: %0d beats of %0d", got_q.size(), total);
    endtask

    task automatic test_watchdog();
        do_reset();
        m_ready = 1'b1;
        for (int round = 0; round < 2; round++) begin
            repeat (TIMEOUT - 1) tick();
            checks++;
            if (timeout !== 1'b0) begin
                errors++;
                $display("FAIL wd_early_r%0d: got %b expected 0", round, timeout);
            end
            tick();
            checks++;
            if (timeout !== 1'b1) begin
                errors++;
                $display("FAIL wd_expire_r%0d: got %b expected 1", round, timeout);
            end
            if (round == 0) begin
                clr_sticky = 1'b1;
                tick();
                clr_sticky = 1'b0;
                checks++;
                if (timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_clear: got %b expected 0", timeout);
                end
            end
        end
        $display("test_watchdog: timeout=%b", timeout);
    endtask

    task automatic test_async_reset();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ch_byte    = 16'($urandom);
            ch_byte_en = 2'b01;
            tick();
        end
        ch_byte_en = '0;
        ch_trap    = 2'b01;
        tick();
        ch_trap    = '0;
        checks++;
        if ({m_valid, trapped} !== 3'b101) begin
            errors++;
            $display("FAIL arst_pre: got valid/trapped %b expected 101", {m_valid, trapped});
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_data, m_chan, overflow, trapped, done, timeout} !== 16'h0) begin
            errors++;
            $display("FAIL arst_outputs: got %h expected 0",
                     {m_valid, m_data, m_chan, overflow, trapped, done, timeout});
        end
        tick();
        resetn  = 1'b1;
        m_ready = 1'b1;
        got_q.delete();
        repeat (20) tick();
        checks++;
        if (got_q.size() !== 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_stale: got %0d beats valid=%b expected 0 beats", got_q.size(), m_valid);
        end
        $display("test_async_reset: stale beats %0d", got_q.size());
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_trap_done();
        test_random();
        test_watchdog();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
